// File: rtl/onehot_demux_1to4_pkg.sv
// Shared one-hot select encoding for the one-hot mux and demux.
// Keeping both helpers here guarantees both sides decode selects identically.
package onehot_demux_1to4_pkg;

    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int IDX_W = $clog2(N);

    function automatic logic is_onehot(input logic [N-1:0] sel);
        int cnt;
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + int'(sel[i]);
        end
        return (cnt == 1);
    endfunction

    // Only meaningful when is_onehot(sel) holds.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N-1:0] sel);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (sel[i]) begin
                idx = i[IDX_W-1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/onehot_demux_slot.sv
// One-entry output register for a single sink; an enqueue wins over a drain
// so back-to-back words flow without a bubble.
module onehot_demux_slot
    import onehot_demux_1to4_pkg::*;
#(
    parameter int WIDTH = onehot_demux_1to4_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enq,
    input  logic [WIDTH-1:0] enq_data,
    input  logic             deq_ready,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    logic             full_reg;
    logic             full_next;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_next;

    always_comb begin
        full_next = full_reg;
        data_next = data_reg;
        if (enq) begin
            full_next = 1'b1;
            data_next = enq_data;
        end else if (deq_ready) begin
            full_next = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            full_reg <= 1'b0;
            data_reg <= '0;
        end else begin
            full_reg <= full_next;
            data_reg <= data_next;
        end
    end

    assign full = full_reg;
    assign data = data_reg;

endmodule

// File: rtl/onehot_demux_1to4.sv
// Registered one-hot demux: one valid/ready source fanned out to four sinks,
// each with its own slot; malformed selects are dropped and counted.
module onehot_demux_1to4
    import onehot_demux_1to4_pkg::*;
#(
    parameter int WIDTH = onehot_demux_1to4_pkg::WIDTH,
    parameter int N     = onehot_demux_1to4_pkg::N
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_bits,
    input  logic [N-1:0]     io_sel,
    output logic             io_out_0_valid,
    input  logic             io_out_0_ready,
    output logic [WIDTH-1:0] io_out_0_bits,
    output logic             io_out_1_valid,
    input  logic             io_out_1_ready,
    output logic [WIDTH-1:0] io_out_1_bits,
    output logic             io_out_2_valid,
    input  logic             io_out_2_ready,
    output logic [WIDTH-1:0] io_out_2_bits,
    output logic             io_out_3_valid,
    input  logic             io_out_3_ready,
    output logic [WIDTH-1:0] io_out_3_bits,
    output logic             io_err,
    output logic [7:0]       io_err_count
);

    logic [N-1:0]     out_ready;
    logic [N-1:0]     full;
    logic [WIDTH-1:0] data [N];
    logic [N-1:0]     enq;
    logic             sel_legal;
    logic [IDX_W-1:0] tgt;
    logic             fire;
    logic             err_reg;
    logic             err_next;
    logic [7:0]       err_count_reg;
    logic [7:0]       err_count_next;

    assign out_ready = {io_out_3_ready, io_out_2_ready, io_out_1_ready, io_out_0_ready};
    assign sel_legal = is_onehot(io_sel);
    assign tgt       = onehot_to_idx(io_sel);

    // Illegal selects are always accepted so a bad word can never wedge the source.
    always_comb begin
        io_in_ready = 1'b0;
        if (!reset) begin
            io_in_ready = sel_legal ? (!full[tgt] || out_ready[tgt]) : 1'b1;
        end
    end

    assign fire = io_in_valid && io_in_ready;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slot
            assign enq[gi] = fire && sel_legal && (tgt == IDX_W'(gi));

            onehot_demux_slot #(.WIDTH(WIDTH)) u_slot (
                .clock     (clock),
                .reset     (reset),
                .enq       (enq[gi]),
                .enq_data  (io_in_bits),
                .deq_ready (out_ready[gi]),
                .full      (full[gi]),
                .data      (data[gi])
            );
        end
    endgenerate

    always_comb begin
        err_next       = fire && !sel_legal;
        err_count_next = err_count_reg;
        if (err_next && (err_count_reg != 8'hFF)) begin
            err_count_next = err_count_reg + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            err_reg       <= 1'b0;
            err_count_reg <= 8'd0;
        end else begin
            err_reg       <= err_next;
            err_count_reg <= err_count_next;
        end
    end

    assign io_err       = err_reg;
    assign io_err_count = err_count_reg;

    assign io_out_0_valid = full[0];
    assign io_out_1_valid = full[1];
    assign io_out_2_valid = full[2];
    assign io_out_3_valid = full[3];
    assign io_out_0_bits  = data[0];
    assign io_out_1_bits  = data[1];
    assign io_out_2_bits  = data[2];
    assign io_out_3_bits  = data[3];

endmodule

// File: tb/tb_onehot_demux_1to4.sv
// Directed bench for onehot_demux_1to4: driver pushes expected words and error
// counts into queues, a negedge monitor pops them as the DUT presents outputs.
module tb_onehot_demux_1to4;

    logic        clock;
    logic        reset;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [31:0] io_in_bits;
    logic [3:0]  io_sel;
    logic [3:0]  rdy;
    logic        v0, v1, v2, v3;
    logic [31:0] b0, b1, b2, b3;
    logic        io_err;
    logic [7:0]  io_err_count;

    int n_cmp;
    int n_bad;
    int err_model;

    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [31:0] q2 [$];
    logic [31:0] q3 [$];
    int          err_q [$];

    onehot_demux_1to4 dut (
        .clock          (clock),
        .reset          (reset),
        .io_in_valid    (io_in_valid),
        .io_in_ready    (io_in_ready),
        .io_in_bits     (io_in_bits),
        .io_sel         (io_sel),
        .io_out_0_valid (v0),
        .io_out_0_ready (rdy[0]),
        .io_out_0_bits  (b0),
        .io_out_1_valid (v1),
        .io_out_1_ready (rdy[1]),
        .io_out_1_bits  (b1),
        .io_out_2_valid (v2),
        .io_out_2_ready (rdy[2]),
        .io_out_2_bits  (b2),
        .io_out_3_valid (v3),
        .io_out_3_ready (rdy[3]),
        .io_out_3_bits  (b3),
        .io_err         (io_err),
        .io_err_count   (io_err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic pop_sink(input int k, input logic [31:0] act);
        logic [31:0] exp;
        bit          empty;
        empty = 1'b0;
        exp   = '0;
        case (k)
            0: if (q0.size() == 0) empty = 1'b1; else exp = q0.pop_front();
            1: if (q1.size() == 0) empty = 1'b1; else exp = q1.pop_front();
            2: if (q2.size() == 0) empty = 1'b1; else exp = q2.pop_front();
            default: if (q3.size() == 0) empty = 1'b1; else exp = q3.pop_front();
        endcase
        if (empty) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sink%0d_unexpected: got 0x%08h expected no word", k, act);
        end else begin
            check($sformatf("sink%0d_bits", k), act, exp);
        end
    endtask

    // Monitor: a word is consumed whenever valid and ready coincide.
    always @(negedge clock) begin
        if (!reset) begin
            if (v0 && rdy[0]) pop_sink(0, b0);
            if (v1 && rdy[1]) pop_sink(1, b1);
            if (v2 && rdy[2]) pop_sink(2, b2);
            if (v3 && rdy[3]) pop_sink(3, b3);
            if (io_err) begin
                if (err_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL err_unexpected: got pulse count %0d expected no pulse", io_err_count);
                end else begin
                    check("err_count_at_pulse", {24'd0, io_err_count}, err_q.pop_front());
                end
            end
        end
    end

    // One source cycle: present the word, check ready, record expectations on fire.
    task automatic cyc(input logic v, input logic [3:0] s, input logic [31:0] b, input logic exp_rdy);
        io_in_valid = v;
        io_sel      = s;
        io_in_bits  = b;
        @(negedge clock);
        check($sformatf("in_ready sel=%b", s), {31'd0, io_in_ready}, {31'd0, exp_rdy});
        if (v && io_in_ready && !reset) begin
            if ($countones(s) == 1) begin
                case (s)
                    4'b0001: q0.push_back(b);
                    4'b0010: q1.push_back(b);
                    4'b0100: q2.push_back(b);
                    default: q3.push_back(b);
                endcase
            end else begin
                if (err_model < 255) err_model++;
                err_q.push_back(err_model);
            end
        end
        @(posedge clock);
        #1;
        io_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        err_model   = 0;
        reset       = 1'b1;
        io_in_valid = 1'b0;
        io_sel      = 4'b0001;
        io_in_bits  = '0;
        rdy         = 4'b0000;

        @(negedge clock);
        check("ready_in_reset", {31'd0, io_in_ready}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("reset_valids", {28'd0, v3, v2, v1, v0}, 32'd0);
        check("reset_err", {31'd0, io_err}, 32'd0);
        check("reset_count", {24'd0, io_err_count}, 32'd0);
        check("reset_bits0", b0, 32'd0);
        @(posedge clock);
        #1;

        // Word to stalled sink 2, then a second word is refused.
        cyc(1'b1, 4'b0100, 32'hDEADBEEF, 1'b1);
        check("s1_valids", {28'd0, v3, v2, v1, v0}, 32'h4);
        check("s1_bits2", b2, 32'hDEADBEEF);
        cyc(1'b1, 4'b0100, 32'hAAAA5555, 1'b0);

        // Simultaneous drain and fill into sink 2.
        rdy[2] = 1'b1;
        cyc(1'b1, 4'b0100, 32'h12345678, 1'b1);
        check("s2_valid2", {31'd0, v2}, 32'd1);
        check("s2_bits2", b2, 32'h12345678);
        idle(2);
        check("s2_drained", {31'd0, v2}, 32'd0);

        // Two consecutive illegal selects, all sinks ready so stray valids get caught.
        rdy = 4'b1111;
        cyc(1'b1, 4'b0011, 32'h11111111, 1'b1);
        cyc(1'b1, 4'b0000, 32'h22222222, 1'b1);
        idle(2);
        check("s3_count", {24'd0, io_err_count}, 32'd2);
        // Invalid cycle with illegal select must not count.
        cyc(1'b0, 4'b1111, 32'h0, 1'b1);
        idle(2);
        check("s3_invalid_ignored", {24'd0, io_err_count}, 32'd2);

        // Sink 0 stalled full does not block sink 3.
        rdy = 4'b0000;
        cyc(1'b1, 4'b0001, 32'h0A0A0A0A, 1'b1);
        cyc(1'b1, 4'b1000, 32'h33333333, 1'b1);
        check("s4_valids", {28'd0, v3, v2, v1, v0}, 32'h9);
        check("s4_bits0", b0, 32'h0A0A0A0A);
        check("s4_bits3", b3, 32'h33333333);
        rdy = 4'b1111;
        idle(2);

        // Alternating sinks at full rate.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, (i % 2 == 0) ? 4'b0001 : 4'b0010, 32'hC0DE0000 + i, 1'b1);
        end
        idle(2);

        // Saturation of the drop counter.
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, (i % 2 == 0) ? 4'b0110 : 4'b0000, i, 1'b1);
        end
        idle(2);
        check("s5_saturated", {24'd0, io_err_count}, 32'd255);

        // Fill all sinks, then reset mid-operation.
        rdy = 4'b0000;
        cyc(1'b1, 4'b0001, 32'h50000000, 1'b1);
        cyc(1'b1, 4'b0010, 32'h50000001, 1'b1);
        cyc(1'b1, 4'b0100, 32'h50000002, 1'b1);
        cyc(1'b1, 4'b1000, 32'h50000003, 1'b1);
        check("s6_all_full", {28'd0, v3, v2, v1, v0}, 32'hF);
        reset = 1'b1;
        cyc(1'b1, 4'b0001, 32'h5EEEEEEE, 1'b0);
        reset = 1'b0;
        q0.delete();
        q1.delete();
        q2.delete();
        q3.delete();
        err_model = 0;
        check("s6_valids_after_reset", {28'd0, v3, v2, v1, v0}, 32'd0);
        check("s6_count_after_reset", {24'd0, io_err_count}, 32'd0);
        rdy = 4'b1111;
        idle(3);

        check("end_queues_empty", q0.size() + q1.size() + q2.size() + q3.size(), 32'd0);
        check("end_err_queue_empty", err_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
